// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: six-state T-cycle ring plus opcode decode into the
// control word for the bus-attached blocks, with a sticky halt flag.
module sap1_controller #(
  parameter int unsigned NUM_T = 6
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [3:0] opcode_i,
  output logic [2:0] t_state_o,
  output logic       hlt_o,
  output logic       co_o,
  output logic       ce_o,
  output logic       mi_o,
  output logic       ro_o,
  output logic       ii_o,
  output logic       io_o,
  output logic       ai_o,
  output logic       ao_o,
  output logic       bi_o,
  output logic       eo_o,
  output logic       su_o,
  output logic       oi_o
);

  localparam logic [3:0] OpLda = 4'h0;
  localparam logic [3:0] OpAdd = 4'h1;
  localparam logic [3:0] OpSub = 4'h2;
  localparam logic [3:0] OpOut = 4'hE;
  localparam logic [3:0] OpHlt = 4'hF;
  localparam logic [2:0] TLast = 3'(NUM_T - 1);

  logic [2:0] t_q, t_d;
  logic       halted_q, halted_d;
  logic       active;
  logic       halt_req;

  // Reset is folded in so every control is forced low while rst_ni is held.
  assign active   = rst_ni & en_i & ~halted_q;
  assign halt_req = active & (t_q == 3'd2) & (opcode_i == OpHlt);

  always_comb begin
    t_d      = t_q;
    halted_d = halted_q;
    if (halt_req) begin
      halted_d = 1'b1;
    end else if (active) begin
      t_d = (t_q == TLast) ? 3'd0 : t_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      t_q      <= 3'd0;
      halted_q <= 1'b0;
    end else begin
      t_q      <= t_d;
      halted_q <= halted_d;
    end
  end

  assign t_state_o = t_q;
  assign hlt_o     = rst_ni & (halted_q | halt_req);

  always_comb begin
    co_o = 1'b0;
    ce_o = 1'b0;
    mi_o = 1'b0;
    ro_o = 1'b0;
    ii_o = 1'b0;
    io_o = 1'b0;
    ai_o = 1'b0;
    ao_o = 1'b0;
    bi_o = 1'b0;
    eo_o = 1'b0;
    su_o = 1'b0;
    oi_o = 1'b0;
    if (active) begin
      case (t_q)
        3'd0: begin
          co_o = 1'b1;
          mi_o = 1'b1;
        end
        3'd1: begin
          ro_o = 1'b1;
          ii_o = 1'b1;
          ce_o = 1'b1;
        end
        3'd2: begin
          case (opcode_i)
            OpLda, OpAdd, OpSub: begin
              io_o = 1'b1;
              mi_o = 1'b1;
            end
            OpOut: begin
              ao_o = 1'b1;
              oi_o = 1'b1;
            end
            default: ;
          endcase
        end
        3'd3: begin
          case (opcode_i)
            OpLda: begin
              ro_o = 1'b1;
              ai_o = 1'b1;
            end
            OpAdd, OpSub: begin
              ro_o = 1'b1;
              bi_o = 1'b1;
            end
            default: ;
          endcase
        end
        3'd4: begin
          if (opcode_i == OpAdd || opcode_i == OpSub) begin
            eo_o = 1'b1;
            ai_o = 1'b1;
            su_o = (opcode_i == OpSub);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sap1_controller.sv
// Bench for sap1_controller: fixed vector table, hand-built halt/enable/reset
// sequences, then random stimulus against a microcode-table reference model.
module tb_sap1_controller;

  localparam logic [12:0] HLT = 13'h1000;
  localparam logic [12:0] CO  = 13'h0800;
  localparam logic [12:0] CE  = 13'h0400;
  localparam logic [12:0] MI  = 13'h0200;
  localparam logic [12:0] RO  = 13'h0100;
  localparam logic [12:0] II  = 13'h0080;
  localparam logic [12:0] IO  = 13'h0040;
  localparam logic [12:0] AI  = 13'h0020;
  localparam logic [12:0] AO  = 13'h0010;
  localparam logic [12:0] BI  = 13'h0008;
  localparam logic [12:0] EO  = 13'h0004;
  localparam logic [12:0] SU  = 13'h0002;
  localparam logic [12:0] OI  = 13'h0001;
  localparam logic [12:0] F0  = CO | MI;
  localparam logic [12:0] F1  = RO | II | CE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] op = 4'h0;
  logic [2:0] t_state;
  logic hlt, co, ce, mi, ro, ii, io, ai, ao, bi, eo, su, oi;
  logic [12:0] word;

  always #5 clk = ~clk;

  sap1_controller #(.NUM_T(6)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .opcode_i(op), .t_state_o(t_state),
    .hlt_o(hlt), .co_o(co), .ce_o(ce), .mi_o(mi), .ro_o(ro), .ii_o(ii), .io_o(io),
    .ai_o(ai), .ao_o(ao), .bi_o(bi), .eo_o(eo), .su_o(su), .oi_o(oi)
  );

  assign word = {hlt, co, ce, mi, ro, ii, io, ai, ao, bi, eo, su, oi};

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: microcode ROM indexed by [opcode][T], plus step and halted flag.
  logic [12:0] mc [16][6];
  int          m_t    = 0;
  bit          m_halt = 1'b0;

  typedef struct {
    bit          r;
    bit          e;
    logic [3:0]  o;
    int          t;
    logic [12:0] w;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [12:0] exp_word();
    if (!rst_n) return 13'h0;
    if (m_halt) return HLT;
    if (!en) return 13'h0;
    return mc[op][m_t];
  endfunction

  task automatic drive(input bit r, input bit e, input logic [3:0] o);
    rst_n = r;
    en    = e;
    op    = o;
    if (!r) begin
      m_t    = 0;
      m_halt = 1'b0;
    end
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n && en && !m_halt) begin
      if (mc[op][m_t][12]) m_halt = 1'b1;
      else m_t = (m_t + 1) % 6;
    end
    #1;
  endtask

  task automatic chk_model(input string name);
    chk({name, " t_state"}, 13'(t_state), 13'(m_t));
    chk({name, " word"}, word, exp_word());
  endtask

  function automatic void add(input bit r, input bit e, input logic [3:0] o, input int t,
                              input logic [12:0] w);
    vq.push_back('{r: r, e: e, o: o, t: t, w: w});
  endfunction

  initial begin
    int ce_cnt;
    int drivers;
    bit r, e;
    logic [3:0] o;

    foreach (mc[i, j]) mc[i][j] = 13'h0;
    for (int i = 0; i < 16; i++) begin
      mc[i][0] = F0;
      mc[i][1] = F1;
    end
    mc[4'h0][2] = IO | MI; mc[4'h0][3] = RO | AI;
    mc[4'h1][2] = IO | MI; mc[4'h1][3] = RO | BI; mc[4'h1][4] = EO | AI;
    mc[4'h2][2] = IO | MI; mc[4'h2][3] = RO | BI; mc[4'h2][4] = EO | AI | SU;
    mc[4'hE][2] = AO | OI;
    mc[4'hF][2] = HLT;

    // Reset, LDA, SUB (opcode noise in fetch), ADD with en drop in T4, OUT, NOP.
    add(0, 1, 4'h0, 0, 13'h0);  add(0, 1, 4'h0, 0, 13'h0);
    add(1, 1, 4'h0, 0, F0);     add(1, 1, 4'h0, 1, F1);
    add(1, 1, 4'h0, 2, IO | MI); add(1, 1, 4'h0, 3, RO | AI);
    add(1, 1, 4'h0, 4, 13'h0);  add(1, 1, 4'h0, 5, 13'h0);
    add(1, 1, 4'h2, 0, F0);     add(1, 1, 4'hF, 1, F1);
    add(1, 1, 4'h2, 2, IO | MI); add(1, 1, 4'h2, 3, RO | BI);
    add(1, 1, 4'h2, 4, EO | AI | SU); add(1, 1, 4'h2, 5, 13'h0);
    add(1, 1, 4'h1, 0, F0);     add(1, 1, 4'h1, 1, F1);
    add(1, 1, 4'h1, 2, IO | MI); add(1, 1, 4'h1, 3, RO | BI);
    add(1, 0, 4'h1, 4, 13'h0);  add(1, 1, 4'h1, 4, EO | AI);
    add(1, 1, 4'h1, 5, 13'h0);
    add(1, 1, 4'hE, 0, F0);     add(1, 1, 4'hE, 1, F1);
    add(1, 1, 4'hE, 2, AO | OI); add(1, 1, 4'hE, 3, 13'h0);
    add(1, 1, 4'hE, 4, 13'h0);  add(1, 1, 4'hE, 5, 13'h0);
    add(1, 1, 4'h7, 0, F0);     add(1, 1, 4'h7, 1, F1);
    add(1, 1, 4'h7, 2, 13'h0);  add(1, 0, 4'h7, 3, 13'h0);
    add(1, 0, 4'h7, 3, 13'h0);  add(1, 1, 4'h7, 3, 13'h0);
    add(1, 1, 4'h7, 4, 13'h0);  add(1, 1, 4'h7, 5, 13'h0);
    add(1, 0, 4'h0, 0, 13'h0);  add(1, 1, 4'h0, 0, F0);

    foreach (vq[i]) begin
      drive(vq[i].r, vq[i].e, vq[i].o);
      chk($sformatf("vec%0d t_state", i), 13'(t_state), 13'(vq[i].t));
      chk($sformatf("vec%0d word", i), word, vq[i].w);
      tick();
    end

    // Halt: reaches T2 with HLT, then freezes for 10 edges whatever en/opcode do.
    drive(0, 1, 4'hF);
    chk("hlt rst word", word, 13'h0);
    tick();
    drive(1, 1, 4'hF);
    chk("hlt t0 word", word, F0);
    tick();
    chk("hlt t1 word", word, F1);
    tick();
    chk("hlt t2 t_state", 13'(t_state), 13'd2);
    chk("hlt t2 word", word, HLT);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1, (i % 3) != 0, 4'(i));
      chk("halted t_state", 13'(t_state), 13'd2);
      chk("halted word", word, HLT);
      tick();
    end
    drive(0, 1, 4'hF);
    chk("unhalt t_state", 13'(t_state), 13'd0);
    chk("unhalt word", word, 13'h0);
    drive(1, 1, 4'h0);
    chk("unhalt t0 word", word, F0);
    tick();

    // Enable dropped at T1 for three edges; ce must fire once.
    ce_cnt = 0;
    drive(1, 0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      chk("en-low t_state", 13'(t_state), 13'd1);
      chk("en-low word", word, 13'h0);
      ce_cnt += int'(ce);
      tick();
    end
    drive(1, 1, 4'h0);
    chk("en-resume word", word, F1);
    ce_cnt += int'(ce);
    tick();
    chk("en-resume t2 word", word, IO | MI);
    ce_cnt += int'(ce);
    chk("ce once", 13'(ce_cnt), 13'd1);
    tick();

    // Async reset between edges in T3.
    chk("pre-async t_state", 13'(t_state), 13'd3);
    chk("pre-async word", word, RO | AI);
    drive(0, 1, 4'h0);
    chk("async t_state", 13'(t_state), 13'd0);
    chk("async word", word, 13'h0);
    drive(1, 1, 4'h0);
    tick();

    // Random stimulus against the model, with bus-invariant check every cycle.
    m_t = 0; m_halt = 1'b0;
    drive(0, 1, 4'h0);
    tick();
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 39) != 0);
      e = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 5))
        0: o = 4'h0;
        1: o = 4'h1;
        2: o = 4'h2;
        3: o = 4'hE;
        default: o = 4'($urandom_range(0, 15));
      endcase
      if (o == 4'hF && $urandom_range(0, 3) != 0) o = 4'h2;
      drive(r, e, o);
      chk_model("rand");
      drivers = int'(co) + int'(ro) + int'(io) + int'(ao) + int'(eo);
      chk("bus invariant", 13'(((drivers > 1) || (su && !eo)) ? 1 : 0), 13'd0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
